// File: rtl/lenet_fp16_pkg.sv
// Shared FP16 definitions for the LeNet output stage: element type, field
// constants, canonical NaN and the argmax reader FSM states.
package lenet_fp16_pkg;

  localparam int FP16_W      = 16;
  localparam int FP16_MAN_W  = 10;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_EXP_LO = FP16_MAN_W;
  localparam int FP16_SIGN   = FP16_W - 1;

  typedef logic [FP16_W-1:0] fp16_t;

  localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = 5'h1F;
  localparam fp16_t                 FP16_QNAN    = 16'h7E00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } argmax_state_e;

  function automatic logic fp16_is_nan(input fp16_t x);
    return (x[FP16_SIGN-1:FP16_EXP_LO] == FP16_EXP_MAX) &&
           (x[FP16_MAN_W-1:0] != '0);
  endfunction

  // Maps sign-magnitude onto an unsigned total order; both zeros share a key.
  function automatic logic [FP16_W-1:0] fp16_key(input fp16_t x);
    if (x[FP16_SIGN-1:0] == '0) return {1'b1, {(FP16_W-1){1'b0}}};
    if (x[FP16_SIGN])           return ~x;
    return {1'b1, x[FP16_SIGN-1:0]};
  endfunction

endpackage

// File: rtl/fp16_greater.sv
// Combinational strict a > b for FP16 with +0 == -0.
// FC_ARGMAX_NAN_SKIP_EN: NaN never wins and always loses; a_is_nan exported.
module fp16_greater
  import lenet_fp16_pkg::*;
(
  input  fp16_t a,
  input  fp16_t b,
`ifdef FC_ARGMAX_NAN_SKIP_EN
  output logic  a_is_nan,
`endif
  output logic  a_gt_b
);

  logic [FP16_W-1:0] key_a, key_b;

  assign key_a = fp16_key(a);
  assign key_b = fp16_key(b);

`ifdef FC_ARGMAX_NAN_SKIP_EN
  logic b_is_nan;
  assign a_is_nan = fp16_is_nan(a);
  assign b_is_nan = fp16_is_nan(b);
  assign a_gt_b   = !a_is_nan && (b_is_nan || (key_a > key_b));
`else
  // NaN falls out of the raw pattern order: +NaN above +inf, -NaN below -inf.
  assign a_gt_b = key_a > key_b;
`endif

endmodule

// File: rtl/fc_argmax_reader.sv
// Captures the FC layer's FP16 logits, scans them one per cycle and returns
// the argmax over valid/ready. FC_ARGMAX_NAN_SKIP_EN excludes NaN elements.
module fc_argmax_reader
  import lenet_fp16_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = $clog2(NUM_CLASSES + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] logits,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [IDX_W-1:0]                  class_idx,
  output logic [DATA_WIDTH-1:0]             max_logit
);

  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_CLASSES - 1);

  argmax_state_e state, state_nxt;

  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] shadow;
  logic [IDX_W-1:0]                       ptr;
  logic [IDX_W-1:0]                       best_idx;
  fp16_t                                  best_val;
  fp16_t                                  cur;
  logic                                   cmp_gt;
  logic                                   take;
  logic                                   capture;
  logic                                   last;
  logic [IDX_W-1:0]                       fin_idx;
  fp16_t                                  fin_val;

  assign capture = (state == ST_IDLE) && start;
  assign last    = (state == ST_SCAN) && (ptr == LAST_PTR);
  assign cur     = shadow[ptr];

`ifdef FC_ARGMAX_NAN_SKIP_EN
  logic cur_nan;
  logic best_vld;

  fp16_greater u_cmp (
    .a        (cur),
    .b        (best_val),
    .a_is_nan (cur_nan),
    .a_gt_b   (cmp_gt)
  );

  // Until a non-NaN element is seen, best holds nothing to compare against.
  assign take = !cur_nan && (!best_vld || cmp_gt);

  always_ff @(posedge clk) begin
    if (reset)        best_vld <= 1'b0;
    else if (capture) best_vld <= 1'b0;
    else if ((state == ST_SCAN) && take) best_vld <= 1'b1;
  end

  always_comb begin
    fin_idx = take ? ptr : best_idx;
    fin_val = take ? cur : best_val;
    if (!take && !best_vld) begin
      fin_idx = IDX_W'(NUM_CLASSES);
      fin_val = FP16_QNAN;
    end
  end
`else
  fp16_greater u_cmp (
    .a      (cur),
    .b      (best_val),
    .a_gt_b (cmp_gt)
  );

  assign take    = (ptr == '0) || cmp_gt;
  assign fin_idx = take ? ptr : best_idx;
  assign fin_val = take ? cur : best_val;
`endif

  // FSM
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_SCAN;
      ST_SCAN: begin
        busy = 1'b1;
        if (ptr == LAST_PTR) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The shadow only needs to be valid from capture onward.
  always_ff @(posedge clk) begin
    if (capture) shadow <= logits;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      best_idx <= '0;
      best_val <= '0;
    end else if (capture) begin
      ptr      <= '0;
      best_idx <= '0;
      best_val <= '0;
    end else if (state == ST_SCAN) begin
      ptr <= ptr + 1'b1;
      if (take) begin
        best_idx <= ptr;
        best_val <= cur;
      end
    end
  end

  // Result registers change only when a scan finishes, so they hold through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      class_idx <= '0;
      max_logit <= '0;
    end else if (last) begin
      class_idx <= fin_idx;
      max_logit <= fin_val;
    end
  end

endmodule

// File: tb/tb_fc_argmax_reader.sv
// Directed bench for fc_argmax_reader: scoreboard of expected results,
// immediate-assertion checks, latency/backpressure/reset/NaN scenarios.
module tb_fc_argmax_reader;

  localparam int NC = 10;
  localparam int DW = 16;
  localparam int IW = $clog2(NC + 1);

  typedef logic [NC-1:0][DW-1:0] vec_t;
  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [NC*DW-1:0] logits;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [IW-1:0]    class_idx;
  logic [DW-1:0]    max_logit;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur_exp;

  fc_argmax_reader #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .logits    (logits),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_idx (class_idx),
    .max_logit (max_logit)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t fill(input logic [DW-1:0] v);
    vec_t r;
    for (int i = 0; i < NC; i++) r[i] = v;
    return r;
  endfunction

  // Drives a start pulse, then scrambles the bus to prove the capture is held.
  task automatic launch(input vec_t v, input logic [IW-1:0] ei, input logic [DW-1:0] ev);
    @(negedge clk);
    logits = v;
    start  = 1'b1;
    sb.push_back('{idx: ei, val: ev});
    @(negedge clk);
    start  = 1'b0;
    logits = fill(16'h7BFF);
    chk("busy_scan", busy, 1);
    chk("valid_scan", out_valid, 0);
  endtask

  task automatic collect(input string tag);
    int e = 0;
    while (!out_valid && e < 40) begin
      @(negedge clk);
      e++;
    end
    chk({tag, "_latency"}, e, NC);
    chk({tag, "_sb"}, sb.size(), 1);
    if (sb.size() != 0) begin
      cur_exp = sb.pop_front();
      chk({tag, "_idx"}, class_idx, cur_exp.idx);
      chk({tag, "_val"}, max_logit, cur_exp.val);
    end
  endtask

  task automatic handshake_done(input string tag);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_valid"}, out_valid, 0);
  endtask

  task automatic run(input string tag, input vec_t v, input logic [IW-1:0] ei,
                     input logic [DW-1:0] ev);
    launch(v, ei, ev);
    collect(tag);
    handshake_done(tag);
  endtask

  initial begin
    vec_t v;
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    logits    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", class_idx, 0);
    chk("rst_val", max_logit, 0);

    v = fill(16'h3C00); v[7] = 16'h4000;
    run("basic", v, 7, 16'h4000);

    v = fill(16'h8000); v[3] = 16'h0000; v[5] = 16'h0000;
    run("zero_tie", v, 0, 16'h8000);

    v[0] = 16'hBC00; v[1] = 16'hC000; v[2] = 16'hC200; v[3] = 16'hC400; v[4] = 16'hC500;
    v[5] = 16'hC600; v[6] = 16'hC700; v[7] = 16'hC800; v[8] = 16'hC880; v[9] = 16'hC900;
    run("all_neg", v, 0, 16'hBC00);

    v = fill(16'h3C00); v[9] = 16'h3C01;
    run("last_idx", v, 9, 16'h3C01);

    v = fill(16'h0000); v[4] = 16'h0001;
    run("denorm", v, 4, 16'h0001);

    v = fill(16'h8000); v[1] = 16'h8001;
    run("neg_denorm", v, 0, 16'h8000);

    // Backpressure with a start pulse inside DONE and on the handshake cycle.
    out_ready = 1'b0;
    v = fill(16'h3C00); v[2] = 16'h4400;
    launch(v, 2, 16'h4400);
    collect("bp");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin start = 1'b1; logits = fill(16'h4800); end
      if (i == 2) start = 1'b0;
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_idx", class_idx, 2);
      chk("bp_hold_val", max_logit, 16'h4400);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bp_hs_busy", busy, 0);
    @(negedge clk);
    chk("bp_start_ignored", busy, 0);
    chk("bp_no_result", out_valid, 0);

    // Reset in the middle of a scan discards the result.
    v = fill(16'h3C00); v[8] = 16'h4000;
    launch(v, 8, 16'h4000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_idx", class_idx, 0);
    chk("mid_rst_val", max_logit, 0);
    v = fill(16'h3C00); v[6] = 16'h4000;
    run("rerun", v, 6, 16'h4000);

    v = fill(16'h3C00); v[2] = 16'h7E00; v[6] = 16'h7C00;
`ifdef FC_ARGMAX_NAN_SKIP_EN
    run("nan_inf", v, 6, 16'h7C00);
    run("all_nan", fill(16'h7E00), IW'(NC), 16'h7E00);
    v = fill(16'h7E00); v[5] = 16'hC000;
    run("nan_one_num", v, 5, 16'hC000);
`else
    run("nan_inf", v, 2, 16'h7E00);
    v = fill(16'h3C00); v[4] = 16'hFE00; v[1] = 16'hFC00; v[0] = 16'hC000;
    for (int i = 0; i < NC; i++) if (i > 1 && i != 4) v[i] = 16'hFC00;
    run("neg_nan_low", v, 0, 16'hC000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
